// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding control for the 5-stage pipeline.
// Optional feature macro: FORWARDING_EN (undefined = stall-only RAW resolution).
module hazard_forward_unit #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             ex_branch_taken,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             stall_if_id,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             reg_write;
      logic             mem_read;
   } tag_t;

   tag_t ex_tag, mem_tag, wb_tag, id_tag;

   logic       a_ex, a_mem, b_ex, b_mem;
   logic       hazard;
   logic [1:0] next_a, next_b;
   logic       tags_unused;

   // x0 is hardwired to zero, so a producer targeting it never matches a consumer
   function automatic logic match(input tag_t t, input logic [REG_W-1:0] rs, input logic used);
      return t.valid & t.reg_write & (t.rd == rs) & (rs != '0) & used;
   endfunction

   assign a_ex  = match(ex_tag,  id_rs1, id_rs1_used);
   assign a_mem = match(mem_tag, id_rs1, id_rs1_used);
   assign b_ex  = match(ex_tag,  id_rs2, id_rs2_used);
   assign b_mem = match(mem_tag, id_rs2, id_rs2_used);

   assign id_tag = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

`ifdef FORWARDING_EN
   logic a_wb, b_wb;

   assign a_wb = match(wb_tag, id_rs1, id_rs1_used);
   assign b_wb = match(wb_tag, id_rs2, id_rs2_used);

   // Only a load in EX cannot be forwarded in time; the youngest producer wins the mux
   always_comb begin
      hazard = id_valid & ex_tag.mem_read & (a_ex | b_ex);
      next_a = a_ex ? 2'd1 : a_mem ? 2'd2 : a_wb ? 2'd3 : 2'd0;
      next_b = b_ex ? 2'd1 : b_mem ? 2'd2 : b_wb ? 2'd3 : 2'd0;
   end

   assign tags_unused = ^{mem_tag.mem_read, wb_tag.mem_read};
`else
   // Without forwarding, any producer still in EX or MEM holds the consumer in ID
   always_comb begin
      hazard = id_valid & (a_ex | a_mem | b_ex | b_mem);
      next_a = 2'd0;
      next_b = 2'd0;
   end

   assign tags_unused = ^{ex_tag.mem_read, mem_tag.mem_read, wb_tag};
`endif

   // A taken branch squashes both younger instructions and wins over any stall
   always_comb begin
      flush_if_id = ex_branch_taken;
      flush_id_ex = ex_branch_taken | hazard;
      stall_if_id = hazard & ~ex_branch_taken;
   end

   // Tag pipeline, registered mux selects and the stall counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         ex_tag       <= '0;
         mem_tag      <= '0;
         wb_tag       <= '0;
         fwd_a_sel    <= 2'd0;
         fwd_b_sel    <= 2'd0;
         stall_cycles <= '0;
      end else begin
         wb_tag    <= mem_tag;
         mem_tag   <= ex_tag;
         ex_tag    <= flush_id_ex ? '0 : id_tag;
         fwd_a_sel <= flush_id_ex ? 2'd0 : next_a;
         fwd_b_sel <= flush_id_ex ? 2'd0 : next_b;
         if (stall_if_id)
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed pipeline scenarios, then
// random instruction streams checked against a history-list reference model.
module tb_hazard_forward_unit;

   localparam int REG_W = 5;
   localparam int CNT_W = 32;

   logic             CLK = 1'b0;
   logic             RST;
   logic             id_valid;
   logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
   logic             id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
   logic             ex_branch_taken;
   logic [1:0]       fwd_a_sel, fwd_b_sel;
   logic             stall_if_id, flush_if_id, flush_id_ex;
   logic [CNT_W-1:0] stall_cycles;

   hazard_forward_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .ex_branch_taken(ex_branch_taken),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .stall_cycles(stall_cycles)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit valid;
      int rd;
      bit wr;
      bit ld;
   } instr_t;

   typedef struct {
      bit     stall;
      bit     fif;
      bit     fidex;
      int     sel_a;
      int     sel_b;
      longint cnt;
   } exp_t;

   exp_t   sb[$];
   instr_t hist[$];
   int     m_sel_a, m_sel_b;
   longint m_cnt;
   int     tests = 0;
   int     fails = 0;

   // hist[0] is the instruction now in EX, hist[1] in MEM, hist[2] in WB
   function automatic bit writes(input instr_t e, input int rs, input bit used);
      return e.valid && e.wr && e.rd == rs && rs != 0 && used;
   endfunction

   function automatic int producer(input int rs, input bit used);
      for (int i = 0; i < hist.size(); i++)
         if (writes(hist[i], rs, used)) return i + 1;
      return 0;
   endfunction

   task automatic modelReset();
      instr_t bub;
      bub = '{valid: 0, rd: 0, wr: 0, ld: 0};
      hist.delete();
      repeat (3) hist.push_back(bub);
      m_sel_a = 0;
      m_sel_b = 0;
      m_cnt   = 0;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("stall_if_id",  64'(stall_if_id),  64'(e.stall));
         checkOutput("flush_if_id",  64'(flush_if_id),  64'(e.fif));
         checkOutput("flush_id_ex",  64'(flush_id_ex),  64'(e.fidex));
         checkOutput("fwd_a_sel",    64'(fwd_a_sel),    64'(e.sel_a));
         checkOutput("fwd_b_sel",    64'(fwd_b_sel),    64'(e.sel_b));
         checkOutput("stall_cycles", 64'(stall_cycles), 64'(e.cnt));
      end
   end

   // Presents one instruction in ID and keeps it there for as long as the model expects a stall
   task automatic applyStimulus(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                                input int rd, input bit wr, input bit ld, input bit br, input bit rst);
      exp_t   e;
      instr_t ni;
      bit     hold, hazard, br_now, rst_now;
      int     iter;
      int     na, nb;
      iter = 0;
      do begin
         br_now          = (iter == 0) ? br : 1'b0;
         rst_now         = (iter == 0) ? rst : 1'b0;
         RST             = rst_now;
         id_valid        = v;
         id_rs1          = REG_W'(rs1);
         id_rs2          = REG_W'(rs2);
         id_rs1_used     = u1;
         id_rs2_used     = u2;
         id_rd           = REG_W'(rd);
         id_reg_write    = wr;
         id_mem_read     = ld;
         ex_branch_taken = br_now;
`ifdef FORWARDING_EN
         hazard = v && hist[0].ld && (writes(hist[0], rs1, u1) || writes(hist[0], rs2, u2));
         na = producer(rs1, u1);
         nb = producer(rs2, u2);
`else
         hazard = v && (writes(hist[0], rs1, u1) || writes(hist[0], rs2, u2) ||
                        writes(hist[1], rs1, u1) || writes(hist[1], rs2, u2));
         na = 0;
         nb = 0;
`endif
         e.stall = hazard && !br_now;
         e.fif   = br_now;
         e.fidex = hazard || br_now;
         e.sel_a = m_sel_a;
         e.sel_b = m_sel_b;
         e.cnt   = m_cnt;
         sb.push_back(e);
         @(posedge CLK);
         #1;
         if (rst_now) begin
            modelReset();
            hold = 0;
         end else begin
            m_sel_a = e.fidex ? 0 : na;
            m_sel_b = e.fidex ? 0 : nb;
            ni = e.fidex ? '{valid: 0, rd: 0, wr: 0, ld: 0} : '{valid: v, rd: rd, wr: wr, ld: ld};
            hist.push_front(ni);
            void'(hist.pop_back());
            if (e.stall) m_cnt = (m_cnt + 1) & 64'hFFFF_FFFF;
            hold = e.stall;
         end
         iter++;
         if (iter > 4 && hold) begin
            tests++;
            fails++;
            $display("[TB] FAIL stall_bound: stall still held after %0d cycles, limit 4", iter);
            hold = 0;
         end
      end while (hold);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      RST = 1'b1;
      id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
      id_rd = '0; id_reg_write = 0; id_mem_read = 0; ex_branch_taken = 0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      modelReset();

      idle(1);
      for (int i = 1; i <= 4; i++) applyStimulus(1, 0, 0, 0, 0, i, 1, 0, 0, 0);
      idle(3);

      // add x5 then sub x6,x5,x1 with zero, one and two gaps
      for (int gap = 0; gap < 3; gap++) begin
         applyStimulus(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
         idle(gap);
         applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
         idle(3);
      end

      // x0 as destination never forwards
      applyStimulus(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 1, 6, 1, 0, 0, 0);
      idle(3);

      // Load-use
      applyStimulus(1, 1, 0, 1, 0, 7, 1, 1, 0, 0);
      applyStimulus(1, 7, 7, 1, 1, 8, 1, 0, 0, 0);
      idle(3);

      // Load-use colliding with a taken branch
      applyStimulus(1, 1, 0, 1, 0, 9, 1, 1, 0, 0);
      applyStimulus(1, 9, 9, 1, 1, 10, 1, 0, 1, 0);
      idle(3);

      // Reset asserted in the stall cycle
      applyStimulus(1, 1, 0, 1, 0, 7, 1, 1, 0, 0);
      applyStimulus(1, 7, 7, 1, 1, 8, 1, 0, 0, 1);
      idle(2);

      for (int n = 0; n < 300; n++) begin
         applyStimulus($urandom_range(0, 9) != 0,
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       int'($urandom_range(0, 7)),
                       $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
      end
      idle(2);

      @(negedge CLK);
      #1;
      checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
